// File: rtl/menu_scroller_if.sv
// menu_scroller_if: bundles the game-state input and the scroller outputs.
// The master side (game controller) drives presente; the slave side
// (menu_scroller) returns the four-digit segment word and the wrap pulse.

interface menu_scroller_if;
   logic [2:0]  presente;
   logic [27:0] display_menu;
   logic        scroll_wrap;

   modport master (
      output presente,
      input  display_menu,
      input  scroll_wrap
   );

   modport slave (
      input  presente,
      output display_menu,
      output scroll_wrap
   );
endinterface

// File: rtl/menu_scroller.sv
// menu_scroller: scrolls a short message right-to-left across four
// active-high 7-segment digits while the game sits in its welcome (WLCM)
// or character-select (CH) screen.  The stream is four blanks followed by
// the five message characters; the window start advances once every
// STEP_DIV clocks.
//
// Build option MENU_LOOP_EN: when defined the window wraps from the last
// stream position back to the all-blank start and scroll_wrap pulses on
// every wrap.  When undefined a single pass is made; the window stops on
// the last four message characters, scroll_wrap pulses once and the step
// counter parks at zero until presente changes or reset.

module menu_scroller #(
   parameter int unsigned STEP_DIV = 6750000
) (
   input  logic           clk,
   input  logic           rst,
   menu_scroller_if.slave bus
);

   localparam logic [2:0]  PRES_WLCM = 3'd1;
   localparam logic [2:0]  PRES_CH   = 3'd2;
   localparam logic [26:0] CNT_LAST  = 27'(STEP_DIV - 1);

`ifdef MENU_LOOP_EN
   localparam logic [3:0]  LAST_POS  = 4'd8;
`else
   localparam logic [3:0]  MSG_LEN   = 4'd5;
`endif

   localparam logic [6:0]  SEG_BLANK = 7'h00;
   localparam logic [6:0]  SEG_H     = 7'h76;
   localparam logic [6:0]  SEG_E     = 7'h79;
   localparam logic [6:0]  SEG_R     = 7'h50;
   localparam logic [6:0]  SEG_O     = 7'h3F;
   localparam logic [6:0]  SEG_L     = 7'h38;
   localparam logic [6:0]  SEG_I     = 7'h06;
   localparam logic [6:0]  SEG_J     = 7'h1E;
   localparam logic [6:0]  SEG_A     = 7'h77;

   logic [26:0] cnt_q;
   logic [26:0] cnt_d;
   logic [3:0]  pos_q;
   logic [3:0]  pos_d;
   logic [2:0]  pres_q;
   logic [27:0] disp_q;
   logic [27:0] disp_d;

   logic        in_menu;
   logic        pres_changed;
   logic        cnt_end;
   logic        pass_done;
   logic        final_step;
   logic        step;

   // Segment code of stream position idx: positions 0..3 are the leading
   // blanks, 4..8 are the message characters of the selected screen.
   function automatic logic [6:0] stream_char(input logic is_ch, input logic [3:0] idx);
      logic [6:0] seg;
      seg = SEG_BLANK;
      if (is_ch) begin
         case (idx)
            4'd4:    seg = SEG_E;
            4'd5:    seg = SEG_L;
            4'd6:    seg = SEG_I;
            4'd7:    seg = SEG_J;
            4'd8:    seg = SEG_A;
            default: seg = SEG_BLANK;
         endcase
      end else begin
         case (idx)
            4'd4:    seg = SEG_H;
            4'd5:    seg = SEG_E;
            4'd6:    seg = SEG_R;
            4'd7:    seg = SEG_O;
            4'd8:    seg = SEG_E;
            default: seg = SEG_BLANK;
         endcase
      end
      return seg;
   endfunction

   // Stream index shown on digit k for window start pos, modulo the
   // nine-entry stream length (pos + k never exceeds 11).
   function automatic logic [3:0] window_idx(input logic [3:0] pos, input logic [1:0] k);
      logic [4:0] sum;
      sum = {1'b0, pos} + {3'b000, k};
      if (sum > 5'd8) begin
         sum = sum - 5'd9;
      end
      return sum[3:0];
   endfunction

   // Decode the screen, spot a presente change and decide whether this
   // cycle is a scroll step and whether that step ends a pass.
   always_comb begin
      in_menu      = (bus.presente == PRES_WLCM) || (bus.presente == PRES_CH);
      pres_changed = (bus.presente != pres_q);
      cnt_end      = (cnt_q == CNT_LAST);
`ifdef MENU_LOOP_EN
      pass_done    = 1'b0;
      final_step   = (pos_q == LAST_POS);
`else
      pass_done    = (pos_q == MSG_LEN);
      final_step   = (pos_q == MSG_LEN - 4'd1);
`endif
      step         = in_menu && !pres_changed && !pass_done && cnt_end;
   end

   // Next step counter and window position: everything restarts on a
   // screen change or outside the menu screens, and a step that lands on
   // a change is dropped because the clear takes priority.
   always_comb begin
      cnt_d = cnt_q + 27'd1;
      pos_d = pos_q;
      if (!in_menu || pres_changed) begin
         cnt_d = '0;
         pos_d = '0;
      end else if (pass_done || cnt_end) begin
         cnt_d = '0;
         if (step) begin
`ifdef MENU_LOOP_EN
            pos_d = final_step ? 4'd0 : pos_q + 4'd1;
`else
            pos_d = pos_q + 4'd1;
`endif
         end
      end
   end

   // Build the four-digit window from the current position, leftmost
   // digit first; outside the menu screens every segment is dark.
   always_comb begin
      disp_d = '0;
      if (in_menu) begin
         for (int k = 0; k < 4; k++) begin
            disp_d = {disp_d[20:0],
                      stream_char(bus.presente == PRES_CH, window_idx(pos_q, 2'(k)))};
         end
      end
   end

   // State and output registers; reset clears everything at once so the
   // display blanks immediately and any pass in flight is abandoned.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         pos_q  <= '0;
         pres_q <= '0;
         disp_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         pos_q  <= pos_d;
         pres_q <= bus.presente;
         disp_q <= disp_d;
      end
   end

   assign bus.display_menu = disp_q;
   assign bus.scroll_wrap  = step && final_step;

endmodule

// File: tb/tb_menu_scroller.sv
// tb_menu_scroller: drives menu_scroller (STEP_DIV = 4) with directed and
// random presente/reset sequences and compares every cycle against a
// string-based model of the scrolling message.  Builds with or without
// MENU_LOOP_EN; the model follows the same macro.

module tb_menu_scroller;

   localparam int unsigned STEP_DIV = 4;
   localparam int          MSG_N    = 5;
   localparam int          STREAM_L = 9;
`ifdef MENU_LOOP_EN
   localparam bit          LOOP_MODE = 1'b1;
`else
   localparam bit          LOOP_MODE = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;

   menu_scroller_if bus();

   menu_scroller #(.STEP_DIV(STEP_DIV)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fails  = 0;

   int          m_pos   = 0;
   int          m_phase = 0;
   logic [2:0]  m_prev  = 3'd0;
   logic [27:0] m_disp  = '0;

   function automatic logic [6:0] seg_of(input byte c);
      case (c)
         "H":     return 7'h76;
         "E":     return 7'h79;
         "r":     return 7'h50;
         "O":     return 7'h3F;
         "L":     return 7'h38;
         "I":     return 7'h06;
         "J":     return 7'h1E;
         "A":     return 7'h77;
         default: return 7'h00;
      endcase
   endfunction

   function automatic bit in_menu(input logic [2:0] code);
      return (code == 3'd1) || (code == 3'd2);
   endfunction

   function automatic logic [27:0] window_of(input logic [2:0] code, input int pos);
      string       stream;
      logic [27:0] w;
      w = '0;
      if (code == 3'd2) stream = "    ELIJA";
      else              stream = "    HErOE";
      for (int k = 0; k < 4; k++) begin
         w = {w[20:0], seg_of(stream[(pos + k) % stream.len()])};
      end
      return w;
   endfunction

   function automatic bit pass_over();
      return !LOOP_MODE && (m_pos == MSG_N);
   endfunction

   function automatic logic exp_wrap();
      int last;
      last = LOOP_MODE ? STREAM_L - 1 : MSG_N - 1;
      return in_menu(bus.presente) && (bus.presente == m_prev) && !pass_over()
             && (m_phase == int'(STEP_DIV) - 1) && (m_pos == last);
   endfunction

   // Reference model: the window start and the clocks elapsed since the
   // last step, advanced once per clock from the scrolling rules.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pos   <= 0;
         m_phase <= 0;
         m_prev  <= 3'd0;
         m_disp  <= '0;
      end else begin
         m_disp <= in_menu(bus.presente) ? window_of(bus.presente, m_pos) : 28'h0;
         m_prev <= bus.presente;
         if (!in_menu(bus.presente) || (bus.presente != m_prev)) begin
            m_pos   <= 0;
            m_phase <= 0;
         end else if (pass_over()) begin
            m_phase <= 0;
         end else if (m_phase == int'(STEP_DIV) - 1) begin
            m_phase <= 0;
            m_pos   <= LOOP_MODE ? (m_pos + 1) % STREAM_L : m_pos + 1;
         end else begin
            m_phase <= m_phase + 1;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [27:0] actual,
                              input logic [27:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fails++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] pres, input logic rst_val);
      #2;
      bus.presente = pres;
      rst          = rst_val;
   endtask

   task automatic waitChange(input int limit, output bit found, output int cycles);
      logic [27:0] start;
      start  = bus.display_menu;
      found  = 1'b0;
      cycles = 0;
      while (!found && cycles < limit) begin
         @(negedge clk);
         cycles++;
         if (bus.display_menu !== start) found = 1'b1;
      end
   endtask

   // Every-cycle comparison of both outputs against the model.
   always @(negedge clk) begin
      checkOutput("display_menu", bus.display_menu, m_disp);
      checkOutput("scroll_wrap", {27'd0, bus.scroll_wrap}, {27'd0, exp_wrap()});
   end

   initial begin
      bit          found;
      int          cycles;
      int          wraps;
      int          lit;
      int          r;
      logic [2:0]  pres;
      logic [27:0] final_win;

      final_win    = {7'h79, 7'h50, 7'h3F, 7'h79};
      bus.presente = 3'd1;
      #1 rst = 1'b1;

      repeat (3) @(negedge clk);
      checkOutput("reset_display", bus.display_menu, 28'h0);
      checkOutput("reset_wrap", {27'd0, bus.scroll_wrap}, 28'h0);
      applyStimulus(3'd1, 1'b0);

      // First two scroll steps after reset in WLCM.
      waitChange(30, found, cycles);
      checkOutput("first_step_seen", {27'd0, found}, 28'd1);
      checkOutput("first_window", bus.display_menu, 28'h0000076);
      waitChange(30, found, cycles);
      checkOutput("second_step_seen", {27'd0, found}, 28'd1);
      checkOutput("second_window", bus.display_menu, 28'h0003B79);
      checkOutput("step_spacing", 28'(cycles), 28'(STEP_DIV));

      // End of the first pass and the pass that follows.
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         if (bus.scroll_wrap === 1'b1) found = 1'b1;
      end
      checkOutput("wrap_seen", {27'd0, found}, 28'd1);
      wraps = 0;
      for (int i = 1; i <= 36; i++) begin
         @(negedge clk);
         if (i == 2) checkOutput("after_wrap_window", bus.display_menu,
                                 LOOP_MODE ? 28'h0 : final_win);
         if (bus.scroll_wrap === 1'b1) wraps++;
      end
      checkOutput("wraps_next_pass", 28'(wraps), LOOP_MODE ? 28'd1 : 28'd0);

      // WLCM -> CH on the step that would leave p = 3.
      @(negedge clk); applyStimulus(3'd0, 1'b0);
      @(negedge clk); applyStimulus(3'd1, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 80 && !found; i++) begin
         @(negedge clk);
         if (m_pos == 3 && m_phase == int'(STEP_DIV) - 1 && bus.presente == m_prev) found = 1'b1;
      end
      checkOutput("p3_step_reached", {27'd0, found}, 28'd1);
      applyStimulus(3'd2, 1'b0);
      repeat (2) @(negedge clk);
      checkOutput("switch_blank", bus.display_menu, 28'h0);
      repeat (4) @(negedge clk);
      checkOutput("switch_first_step", bus.display_menu, 28'h0000079);

      // Reset in the middle of a WLCM pass.
      @(negedge clk); applyStimulus(3'd0, 1'b0);
      @(negedge clk); applyStimulus(3'd1, 1'b0);
      repeat (13) @(negedge clk);
      applyStimulus(3'd1, 1'b1);
      @(negedge clk);
      checkOutput("midpass_reset_display", bus.display_menu, 28'h0);
      checkOutput("midpass_reset_wrap", {27'd0, bus.scroll_wrap}, 28'h0);
      applyStimulus(3'd1, 1'b0);
      @(negedge clk);
      checkOutput("post_reset_display", bus.display_menu, 28'h0);
      wraps = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (bus.scroll_wrap === 1'b1) wraps++;
      end
      checkOutput("post_reset_wraps", 28'(wraps), 28'd0);

      // GAME screen keeps the display dark.
      applyStimulus(3'd3, 1'b0);
      wraps = 0;
      lit   = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.scroll_wrap !== 1'b0) wraps++;
         if (bus.display_menu !== 28'h0) lit++;
      end
      checkOutput("game_wraps", 28'(wraps), 28'd0);
      checkOutput("game_lit", 28'(lit), 28'd0);

      // Random screen changes and occasional resets.
      pres = 3'd1;
      for (int i = 0; i < 1200; i++) begin
         @(negedge clk);
         r = int'($urandom_range(0, 99));
         if (r < 2) begin
            r = int'($urandom_range(0, 9));
            if (r < 4)      pres = 3'd1;
            else if (r < 8) pres = 3'd2;
            else            pres = 3'($urandom_range(0, 7));
         end
         applyStimulus(pres, (rst == 1'b0) && ($urandom_range(0, 299) == 0));
      end
      @(negedge clk); applyStimulus(pres, 1'b0);
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected end of stimulus");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
